// File: rtl/apb_regfile_if.sv
// APB bus bundle for the register file.
// Master drives the request; slave returns ready, data and error.
interface apb_regfile_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite,
    output paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regfile.sv
// APB register file with byte strobes, wait states,
// read-only hardware-fed registers and write pulses.
module apb_regfile #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                         pclk,
  input  logic                         rst,
  apb_regfile_if.slave                 bus,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam logic [ADDR_W-1:0] AMASK =
    ADDR_W'((1 << LSB) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state_q, state_d, phase;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] widx;
  logic [NUM_REGS-1:0] hit;
  logic [DATA_W-1:0] rd_sel;
  logic oor, misal, ro_hit, err;
  logic done, commit;

  assign widx  = bus.paddr >> LSB;
  assign oor   = {1'b0, widx} >= (ADDR_W+1)'(NUM_REGS);
  assign misal = |(bus.paddr & AMASK);

  always_comb begin
    hit    = '0;
    ro_hit = 1'b0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (widx == ADDR_W'(i)) begin
        hit[i] = 1'b1;
        ro_hit = RO_MASK[i];
        rd_sel = RO_MASK[i] ?
          hw_in[i*DATA_W +: DATA_W] : regs[i];
      end
    end
  end

  assign err = oor | misal | (bus.pwrite & ro_hit);

  // The setup cycle is recognised combinationally so
  // the first penable cycle already counts as ACCESS.
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && bus.psel && !bus.penable)
      phase = SETUP;
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (phase)
      IDLE: ;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (cnt_q == 4'(WAIT_STATES)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pready  = done;
  assign bus.pslverr = done & err;
  assign bus.prdata  =
    (done && !bus.pwrite && !err) ? rd_sel : '0;
  assign commit = done & bus.pwrite & ~err;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && hit[i] && !RO_MASK[i]) begin
          for (int b = 0; b < NB; b++)
            if (bus.pstrb[b])
              regs[i][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
          wr_pulse[i] <= |bus.pstrb;
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_W +: DATA_W] =
        RO_MASK[i] ? '0 : regs[i];
  end
endmodule

// File: doc/apb_regfile.md
APB_REGFILE -- requirements
Module: apb_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (legal: 8, 16, 32, 64).
REQ-003 SHALL have parameter NUM_REGS, default 8, register count (1..2**(ADDR_W-log2(DATA_W/8))).
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra access-phase cycles before pready (0..15).
REQ-005 SHALL have parameter RO_MASK, default 0, NUM_REGS bits; bit i=1 makes register i read-only.
REQ-006 SHALL have port pclk, input, 1, sole clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port paddr, input, ADDR_W, byte address.
REQ-009 SHALL have ports psel, penable and pwrite, input, 1 each, APB select, enable and direction (1 = write).
REQ-010 SHALL have port pwdata, input, DATA_W, write data.
REQ-011 SHALL have port pstrb, input, DATA_W/8, write byte strobes.
REQ-012 SHALL have port pready, output, 1, transfer completion.
REQ-013 SHALL have port prdata, output, DATA_W, read data.
REQ-014 SHALL have port pslverr, output, 1, transfer error.
REQ-015 SHALL have port hw_in, input, NUM_REGS*DATA_W, read value for read-only registers (register i at bits [i*DATA_W +: DATA_W]).
REQ-016 SHALL have port reg_q, output, NUM_REGS*DATA_W, current read/write register contents, same packing.
REQ-017 SHALL have port wr_pulse, output, NUM_REGS, one-cycle strobe per committed write.

Function
REQ-018 SHALL implement FSM with states IDLE, SETUP and ACCESS.
REQ-019 IDLE->SETUP SHALL occur when psel=1 and penable=0; all other IDLE inputs SHALL be ignored.
REQ-020 SETUP->ACCESS SHALL occur unconditionally on the next edge; the wait counter SHALL clear to 0.
REQ-021 In ACCESS, pready SHALL be 1 exactly when the counter equals WAIT_STATES; otherwise the counter SHALL increment.
REQ-022 Timing: setup cycle T, first penable cycle T+1, pready=1 in cycle T+1+WAIT_STATES only; prdata and pslverr SHALL be 0 in every other cycle.
REQ-023 ACCESS->IDLE SHALL occur after the pready cycle; SETUP SHALL be entered directly if psel=1 and penable=0 in the following cycle (back-to-back).
REQ-024 If psel drops while in ACCESS before pready, the FSM SHALL return to IDLE with no register update and no pulse.
REQ-025 Word index SHALL be paddr[ADDR_W-1:log2(DATA_W/8)].
REQ-026 pslverr SHALL be 1 with pready if any of: word index >= NUM_REGS; nonzero paddr[log2(DATA_W/8)-1:0]; write to a RO_MASK register.
REQ-027 On an error write, no register SHALL change and no wr_pulse SHALL fire; on an error read, prdata SHALL be 0.
REQ-028 A valid write SHALL update register bytes whose pstrb bit is 1 at the edge ending the pready cycle; other bytes SHALL be unchanged.
REQ-029 wr_pulse[i] SHALL be 1 in the cycle after a valid write with at least one pstrb bit set; pstrb all-zero SHALL cause no change, no pulse and no error.
REQ-030 A valid read SHALL return reg_q slice i for read/write registers and hw_in slice i (sampled in the pready cycle) for RO registers.
REQ-031 RO registers' reg_q slice SHALL read as 0 permanently.

Reset
REQ-032 While rst=1: FSM=IDLE, counter=0, pready=0, prdata=0, pslverr=0, reg_q=0, wr_pulse=0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer immediately; no partial write SHALL persist.
REQ-034 After rst deasserts, the first legal setup cycle SHALL be accepted.

Verification
REQ-035 WAIT_STATES=0: write 0xDEADBEEF to 0x004, pstrb=0xF -> pready at T+1, reg 1=0xDEADBEEF, wr_pulse[1] at T+2; read 0x004 -> prdata=0xDEADBEEF.
REQ-036 WAIT_STATES=3: read 0x000 -> pready low T+1..T+3, high only at T+4, pslverr=0.
REQ-037 Write 0x11223344 with pstrb=0x5 over 0xAABBCCDD -> register=0xAA22CC44.
REQ-038 Access 0x020 (index 8, NUM_REGS=8), 0x002 (unaligned) and a write to RO_MASK bit 2 -> pslverr=1, no pulse, registers unchanged; read of RO reg 2 with hw_in slice 2=0x5A5A -> prdata=0x5A5A.
REQ-039 WAIT_STATES=2: assert rst in cycle T+2 of a write -> outputs 0, target register 0, no wr_pulse; next transfer after release completes normally.
REQ-040 Back-to-back write then read to 0x008 with no idle cycle -> both complete, read returns the written data.
